// File: rtl/wall_map.sv
// wall_map: one-bit-per-cell wall store for the 64x44 tank play field.
// Two registered read ports, a deferred clear FIFO drained outside active video, and a default-map builder.
`default_nettype none

module wall_map #(
  parameter int MAP_W      = 64,
  parameter int MAP_H      = 44,
  parameter int FIFO_DEPTH = 4,
  parameter int XW         = 6,
  parameter int YW         = 6
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            i_vga_busy,
  input  logic [XW-1:0]                   i_vga_x,
  input  logic [YW-1:0]                   i_vga_y,
  output logic                            o_vga_is_wall,
  input  logic [XW-1:0]                   i_q_x,
  input  logic [YW-1:0]                   i_q_y,
  output logic                            o_q_is_wall,
  input  logic                            i_init,
  output logic                            o_ready,
  input  logic                            i_clr_valid,
  input  logic [XW-1:0]                   i_clr_x,
  input  logic [YW-1:0]                   i_clr_y,
  output logic                            o_clr_ready,
  output logic [$clog2(FIFO_DEPTH):0]     o_pending
);

  localparam int N    = MAP_W * MAP_H;
  localparam int AW   = $clog2(N);
  localparam int PTRW = $clog2(FIFO_DEPTH);
  localparam int PW   = PTRW + 1;

  localparam logic [XW:0]     C_W     = (XW+1)'(MAP_W);
  localparam logic [YW:0]     C_H     = (YW+1)'(MAP_H);
  localparam logic [XW-1:0]   C_XMAX  = XW'(MAP_W - 1);
  localparam logic [YW-1:0]   C_YMAX  = YW'(MAP_H - 1);
  localparam logic [AW-1:0]   C_WA    = AW'(MAP_W);
  localparam logic [PW-1:0]   C_DEPTH = PW'(FIFO_DEPTH);

  typedef enum logic {S_INIT = 1'b0, S_RUN = 1'b1} state_e;

  function automatic logic in_range(input logic [XW-1:0] x, input logic [YW-1:0] y);
    return ({1'b0, x} < C_W) && ({1'b0, y} < C_H);
  endfunction

  function automatic logic [AW-1:0] cell_idx(input logic [XW-1:0] x, input logic [YW-1:0] y);
    return AW'(y) * C_WA + AW'(x);
  endfunction

  function automatic logic default_wall(input logic [XW-1:0] x, input logic [YW-1:0] y);
    logic border;
    logic pillar;
    border = (x == '0) || (x == C_XMAX) || (y == '0) || (y == C_YMAX);
    pillar = (x[3:0] == 4'd8) && (y[2:0] >= 3'd2) && (y[2:0] <= 3'd5);
    return border || pillar;
  endfunction

  logic           mem_q [N];

  state_e         state_q, state_d;
  logic [XW-1:0]  scan_x_q, scan_x_d;
  logic [YW-1:0]  scan_y_q, scan_y_d;
  logic           ready_q, ready_d;
  logic           clr_ready_q, clr_ready_d;
  logic [XW-1:0]  fifo_x_q [FIFO_DEPTH];
  logic [YW-1:0]  fifo_y_q [FIFO_DEPTH];
  logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]  count_q, count_d;
  logic           vga_wall_q, q_wall_q;

  logic           push, pop;
  logic           mem_we;
  logic [AW-1:0]  mem_waddr;
  logic           mem_wdata;

  logic           vga_in, q_in;
  logic [AW-1:0]  vga_idx, q_idx;

  always_comb begin
    state_d   = state_q;
    scan_x_d  = scan_x_q;
    scan_y_d  = scan_y_q;
    ready_d   = ready_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;

    if (i_init) begin
      // Rebuild wins over any pending FIFO traffic; queued clears are discarded.
      state_d  = S_INIT;
      scan_x_d = '0;
      scan_y_d = '0;
      ready_d  = 1'b0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      case (state_q)
        S_INIT: begin
          mem_we    = 1'b1;
          mem_waddr = cell_idx(scan_x_q, scan_y_q);
          mem_wdata = default_wall(scan_x_q, scan_y_q);
          if (scan_x_q == C_XMAX) begin
            scan_x_d = '0;
            if (scan_y_q == C_YMAX) begin
              scan_y_d = '0;
              state_d  = S_RUN;
              ready_d  = 1'b1;
            end else begin
              scan_y_d = scan_y_q + 1'b1;
            end
          end else begin
            scan_x_d = scan_x_q + 1'b1;
          end
        end
        S_RUN: begin
          push = i_clr_valid && clr_ready_q;
          pop  = (count_q != '0) && !i_vga_busy;
          if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            if (in_range(fifo_x_q[rd_ptr_q], fifo_y_q[rd_ptr_q])) begin
              mem_we    = 1'b1;
              mem_waddr = cell_idx(fifo_x_q[rd_ptr_q], fifo_y_q[rd_ptr_q]);
              mem_wdata = 1'b0;
            end
          end
          if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
          end
          case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
          endcase
        end
        default: state_d = S_INIT;
      endcase
    end

    clr_ready_d = (state_d == S_RUN) && (count_d < C_DEPTH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_INIT;
      scan_x_q    <= '0;
      scan_y_q    <= '0;
      ready_q     <= 1'b0;
      clr_ready_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      scan_x_q    <= scan_x_d;
      scan_y_q    <= scan_y_d;
      ready_q     <= ready_d;
      clr_ready_q <= clr_ready_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  // Map and FIFO payload are plain storage with no reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
    if (push) begin
      fifo_x_q[wr_ptr_q] <= i_clr_x;
      fifo_y_q[wr_ptr_q] <= i_clr_y;
    end
  end

  always_comb begin
    vga_in  = in_range(i_vga_x, i_vga_y);
    q_in    = in_range(i_q_x, i_q_y);
    vga_idx = vga_in ? cell_idx(i_vga_x, i_vga_y) : '0;
    q_idx   = q_in   ? cell_idx(i_q_x, i_q_y)     : '0;
  end

  // Reads see the pre-write cell contents when a write lands on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_wall_q <= 1'b0;
      q_wall_q   <= 1'b0;
    end else begin
      vga_wall_q <= (state_q == S_INIT) || !vga_in || mem_q[vga_idx];
      q_wall_q   <= (state_q == S_INIT) || !q_in   || mem_q[q_idx];
    end
  end

  assign o_vga_is_wall = vga_wall_q;
  assign o_q_is_wall   = q_wall_q;
  assign o_ready       = ready_q;
  assign o_clr_ready   = clr_ready_q;
  assign o_pending     = count_q;

endmodule

`default_nettype wire

// File: tb/tb_wall_map.sv
// tb_wall_map: directed stimulus with a queue/array reference model checked every cycle.
`default_nettype none

module tb_wall_map;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_vga_busy;
  logic [5:0] i_vga_x, i_vga_y;
  logic       o_vga_is_wall;
  logic [5:0] i_q_x, i_q_y;
  logic       o_q_is_wall;
  logic       i_init;
  logic       o_ready;
  logic       i_clr_valid;
  logic [5:0] i_clr_x, i_clr_y;
  logic       o_clr_ready;
  logic [2:0] o_pending;

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 1'b0;

  always #5 clk = ~clk;

  wall_map dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_vga_busy   (i_vga_busy),
    .i_vga_x      (i_vga_x),
    .i_vga_y      (i_vga_y),
    .o_vga_is_wall(o_vga_is_wall),
    .i_q_x        (i_q_x),
    .i_q_y        (i_q_y),
    .o_q_is_wall  (o_q_is_wall),
    .i_init       (i_init),
    .o_ready      (o_ready),
    .i_clr_valid  (i_clr_valid),
    .i_clr_x      (i_clr_x),
    .i_clr_y      (i_clr_y),
    .o_clr_ready  (o_clr_ready),
    .o_pending    (o_pending)
  );

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit m_map [64*44];
  bit m_run = 1'b0;
  int m_cnt = 0;
  int m_q[$];
  int e_vga = 0, e_q = 0, e_ready = 0, e_clr_ready = 0, e_pending = 0;

  function automatic bit model_default(input int x, input int y);
    return (x == 0) || (x == 63) || (y == 0) || (y == 43) ||
           ((x % 16 == 8) && (y % 8 >= 2) && (y % 8 <= 5));
  endfunction

  function automatic int model_read(input int x, input int y);
    if (!m_run || x >= 64 || y >= 44) return 1;
    return int'(m_map[y*64 + x]);
  endfunction

  initial begin
    int nv, nq, ent, cx, cy;
    bit do_push;
    forever begin
      @(posedge clk);
      if (rst_n === 1'b1) begin
        nv = model_read(int'(i_vga_x), int'(i_vga_y));
        nq = model_read(int'(i_q_x), int'(i_q_y));
        if (i_init) begin
          m_run = 1'b0; m_cnt = 0; m_q.delete(); e_ready = 0;
        end else if (!m_run) begin
          m_map[m_cnt] = model_default(m_cnt % 64, m_cnt / 64);
          m_cnt++;
          if (m_cnt == 64*44) begin m_run = 1'b1; e_ready = 1; end
        end else begin
          do_push = i_clr_valid && (e_clr_ready == 1);
          if (m_q.size() > 0 && !i_vga_busy) begin
            ent = m_q.pop_front();
            cx = ent / 256; cy = ent % 256;
            if (cx < 64 && cy < 44) m_map[cy*64 + cx] = 1'b0;
          end
          if (do_push) m_q.push_back(int'(i_clr_x) * 256 + int'(i_clr_y));
        end
        e_pending   = m_q.size();
        e_clr_ready = (m_run && m_q.size() < 4) ? 1 : 0;
        e_vga = nv;
        e_q   = nq;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        check("cyc_vga",       int'(o_vga_is_wall), e_vga);
        check("cyc_q",         int'(o_q_is_wall),   e_q);
        check("cyc_ready",     int'(o_ready),       e_ready);
        check("cyc_clr_ready", int'(o_clr_ready),   e_clr_ready);
        check("cyc_pending",   int'(o_pending),     e_pending);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic query(input int x, input int y);
    i_q_x = 6'(x);
    i_q_y = 6'(y);
  endtask

  int qx [7] = '{0, 8, 8, 5, 63, 64, 10};
  int qy [7] = '{10, 2, 1, 5, 43, 0, 44};
  int qe [7] = '{1, 1, 0, 0, 1, 1, 1};

  initial begin
    int n;
    rst_n = 1'b1;
    i_vga_busy = 1'b0; i_vga_x = '0; i_vga_y = '0;
    i_q_x = 6'd5; i_q_y = 6'd5;
    i_init = 1'b0; i_clr_valid = 1'b0; i_clr_x = '0; i_clr_y = '0;
    #1 rst_n = 1'b0;
    cmp_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_vga", int'(o_vga_is_wall), 0);
    check("rst_q", int'(o_q_is_wall), 0);
    check("rst_ready", int'(o_ready), 0);
    check("rst_clr_ready", int'(o_clr_ready), 0);
    check("rst_pending", int'(o_pending), 0);
    rst_n = 1'b1;

    for (int k = 1; k <= 2816; k++) begin
      step();
      if (k == 10)   check("init_q55", int'(o_q_is_wall), 1);
      if (k == 2815) check("ready_2815", int'(o_ready), 0);
      if (k == 2816) check("ready_2816", int'(o_ready), 1);
    end

    for (int i = 0; i < 7; i++) begin
      query(qx[i], qy[i]);
      i_vga_x = 6'(qx[(i+3)%7]);
      i_vga_y = 6'(qy[(i+3)%7]);
      step();
      check($sformatf("q_pat%0d", i), int'(o_q_is_wall), qe[i]);
      check($sformatf("vga_pat%0d", i), int'(o_vga_is_wall), qe[(i+3)%7]);
    end
    query(20, 20);

    // Fill FIFO while busy, overflow push is dropped.
    i_vga_busy = 1'b1;
    i_clr_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      i_clr_x = 6'd8; i_clr_y = 6'(2 + k);
      step();
    end
    check("full_pending", int'(o_pending), 4);
    check("full_clr_ready", int'(o_clr_ready), 0);
    i_clr_x = 6'd0; i_clr_y = 6'd5;
    step();
    i_clr_valid = 1'b0;
    check("drop_pending", int'(o_pending), 4);
    query(8, 2);
    step();
    check("busy_hold_82", int'(o_q_is_wall), 1);
    query(20, 20);
    i_vga_busy = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("drain_pending%0d", k), int'(o_pending), 3 - k);
    end
    for (int k = 0; k < 4; k++) begin
      query(8, 2 + k);
      step();
      check($sformatf("cleared_8_%0d", 2 + k), int'(o_q_is_wall), 0);
    end
    query(0, 5);
    step();
    check("dropped_05_still_wall", int'(o_q_is_wall), 1);

    // Push on the same edge as a pop; order must be preserved.
    query(20, 20);
    i_vga_busy = 1'b1;
    i_clr_valid = 1'b1;
    i_clr_x = 6'd24; i_clr_y = 6'd2; step();
    i_clr_x = 6'd24; i_clr_y = 6'd3; step();
    i_clr_valid = 1'b0;
    check("pp_pending2", int'(o_pending), 2);
    i_vga_busy = 1'b0;
    i_clr_valid = 1'b1; i_clr_x = 6'd24; i_clr_y = 6'd4;
    step();
    i_clr_valid = 1'b0;
    check("pp_pending_same", int'(o_pending), 2);
    query(24, 4); step();
    check("pp_c_not_yet", int'(o_q_is_wall), 1);
    query(24, 3); step();
    check("pp_b_cleared", int'(o_q_is_wall), 0);
    query(24, 4); step();
    check("pp_c_cleared", int'(o_q_is_wall), 0);
    check("pp_empty", int'(o_pending), 0);

    // Read on the commit edge sees the old value.
    i_vga_busy = 1'b1;
    i_clr_valid = 1'b1; i_clr_x = 6'd40; i_clr_y = 6'd3;
    step();
    i_clr_valid = 1'b0;
    i_vga_busy = 1'b0;
    query(40, 3);
    step();
    check("coll_pre_write", int'(o_q_is_wall), 1);
    step();
    check("coll_post_write", int'(o_q_is_wall), 0);

    // Rebuild with pending clears; they must never commit.
    i_vga_busy = 1'b1;
    i_clr_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      i_clr_x = 6'd56; i_clr_y = 6'(2 + k);
      step();
    end
    i_clr_valid = 1'b0;
    check("ri_pending3", int'(o_pending), 3);
    i_vga_busy = 1'b0;
    i_init = 1'b1;
    step();
    i_init = 1'b0;
    check("ri_pending0", int'(o_pending), 0);
    check("ri_ready0", int'(o_ready), 0);
    n = 0;
    while (o_ready !== 1'b1 && n < 3000) begin
      step();
      n++;
    end
    check("ri_edges_to_ready", n, 2816);
    query(56, 2); step();
    check("ri_56_2_wall", int'(o_q_is_wall), 1);
    query(8, 2); step();
    check("ri_8_2_restored", int'(o_q_is_wall), 1);
    step();

    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
